dr_link_rx: RTL and testbench
=============================

Name: dr_link_rx

Overview:
- Clocked, synthesizable receiver for dual-rail asynchronous links; successor to the behavioural testbench link monitor.
- Samples a WIDTH-bit dual-rail link and detects token completion in either two-phase (TP) or four-phase (FP) encoding.
- Decodes each token to a binary word, buffers words in a FIFO with a valid/ready output, and drives the link acknowledge.
- Adds backpressure, a programmable ack delay, protocol-error detection and a token counter; sits at async-to-sync boundaries and in benches.

Parameters:
ENC, "TP", link encoding: "TP" two-phase (transition) or "FP" four-phase (return-to-zero)
WIDTH, 8, data bits per token (rails per bit fixed at 2; rail1 = logic 1)
SYNC_STAGES, 2, synchronizer flops per rail (≥2)
FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
ACK_DELAY, 0, extra clk cycles between qualified completion and ack change
CNT_W, 16, token/error counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in  in  WIDTH×2  dual-rail link data, asynchronous to clk
ack_o  out  1  link acknowledge (TP: toggles per token; FP: level)
out_data  out  WIDTH  decoded word
out_err  out  1  word carried a protocol error
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head word
err_o  out  1  sticky protocol-error flag
err_clr  in  1  clears err_o and err_cnt
tok_cnt  out  CNT_W  tokens accepted, saturating
err_cnt  out  CNT_W  erroneous tokens, saturating

Behaviour:
- Reset (async assert, sync release): ack_o=0, in_state=0, FIFO empty, out_valid=0, err_o=0, counters=0, FSM=IDLE. Reset mid-token discards the token.
- Synchronization: each rail passes through SYNC_STAGES flops to give s_in; all logic uses s_in.
- Per-bit diff d = s_in ^ in_state (TP) or d = s_in (FP).
  - Bit complete when d ∈ {01,10}; value = d[1]; illegal when d = 11.
- Qualification: a completion counts only if every bit is complete-or-illegal and s_in is identical on 2 consecutive cycles (skew filter).
- FSM:
  - IDLE → HOLD on qualified completion. Capture word and err = OR(illegal bits).
  - HOLD: count ACK_DELAY cycles. At 0, if FIFO not full, or full with a pop this cycle, go to ACK; otherwise stay in HOLD (backpressure, ack withheld).
  - ACK (1 cycle): push {err, word}; increment tok_cnt; increment err_cnt and set err_o if err.
    - TP: ack_o toggles, in_state <= s_in, → IDLE.
    - FP: ack_o <= 1, → SPACER.
  - SPACER (FP only): wait until all s_in rails = 0 for 2 consecutive cycles, then ack_o <= 0 → IDLE. A nonzero rail pattern here is ignored.
- Latency: in change to ack_o change = SYNC_STAGES + 1 (qualify) + 1 + ACK_DELAY + 1 cycles, minimum 5 with defaults.
- FIFO:
  - Word is visible on out_data/out_valid the cycle after push.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both legal when full or empty (empty: push only; the word appears next cycle).
- Counters saturate at 2^CNT_W−1. err_clr has priority over a same-cycle error increment; err_clr does not affect tok_cnt.
- Partial tokens (some bits with d=00) never qualify; the FSM stays in IDLE indefinitely.

Decomposition:
- Package link_pkg: enc_e {ENC_TP, ENC_FP}; rx_state_e {IDLE, HOLD, ACK, SPACER}; RAIL_NUM=2; functions dr_decode(d) → value and dr_illegal(d).
- Sub-module sync_fifo (WIDTH+1 wide, FIFO_DEPTH deep, full/empty/push/pop). Synchronizer chain stays inline in a generate loop.

Test Plan:
- TP, WIDTH=8: drive token 0xA5 (toggle rail1 on bits 0,2,5,7 and rail0 on the others) with out_ready=1 → out_data=0xA5, out_err=0, ack_o 0→1 exactly 5 cycles after the input change, tok_cnt=1. A second token 0x5A → ack_o 1→0, tok_cnt=2.
- FP, WIDTH=4: drive 0x9, then spacer, ×3 → three words 0x9; ack_o rises after each data phase and falls only after all-zero rails; never acks a spacer.
- Backpressure, FIFO_DEPTH=4, out_ready=0: send 5 tokens → 4 acked, the 5th held in HOLD with ack_o unchanged. Assert out_ready for 1 cycle → 5th acked the same cycle, FIFO stays full.
- Skew: bits 0..3 of token 0xFF arrive 3 cycles before bits 4..7 → no out_valid and no ack until all bits complete; then a single word 0xFF.
- Error: TP token with bit 2 toggling both rails → out_err=1, err_o=1, err_cnt=1, token still acked. Pulse err_clr → err_o=0, err_cnt=0, tok_cnt unchanged.
- Reset mid-op: assert rst_n=0 while in HOLD with 2 words queued → immediately ack_o=0, out_valid=0, counters 0. After release, the first new token decodes correctly against in_state=0.

Source files
------------

// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared types and dual-rail decode helpers for the link receiver
package link_pkg;

    typedef enum logic {ENC_TP, ENC_FP} enc_e;
    typedef enum logic [1:0] {IDLE, HOLD, ACK, SPACER} rx_state_e;

    localparam int RAIL_NUM = 2;

    function automatic logic dr_decode(input logic [RAIL_NUM-1:0] d);
        return d[1];
    endfunction

    function automatic logic dr_illegal(input logic [RAIL_NUM-1:0] d);
        return &d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty and push-while-full-with-pop
module sync_fifo #(
    parameter int DW    = 9,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/dr_link_rx.sv
// rtl/dr_link_rx.sv - dual-rail (two- or four-phase) link receiver with word FIFO and ack
module dr_link_rx
    import link_pkg::*;
#(
    parameter     ENC         = "TP",
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_DELAY   = 0,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH*RAIL_NUM-1:0] in,
    output logic                      ack_o,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      err_o,
    input  logic                      err_clr,
    output logic [CNT_W-1:0]          tok_cnt,
    output logic [CNT_W-1:0]          err_cnt
);
    localparam enc_e LP_ENC = (ENC == "FP") ? ENC_FP : ENC_TP;
    localparam int   RW     = WIDTH * RAIL_NUM;
    localparam int   DLY_W  = (ACK_DELAY > 0) ? $clog2(ACK_DELAY + 1) : 1;

    logic [SYNC_STAGES:0][RW-1:0] w_chain;
    logic [RW-1:0]    w_s_in, w_d, r_s_prev, r_in_state;
    logic [WIDTH-1:0] w_word, r_word;
    logic             w_all_done, w_err, w_qual, w_spacer, r_err;
    logic             w_full, w_empty, w_pop, w_go_ack;
    logic [DLY_W-1:0] r_dly;
    rx_state_e        r_state, w_state_nxt;

    assign w_chain[0] = in;
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic [RW-1:0] r_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_q <= '0;
            else        r_q <= w_chain[g];
        end
        assign w_chain[g+1] = r_q;
    end
    assign w_s_in = w_chain[SYNC_STAGES];

    assign w_d = (LP_ENC == ENC_TP) ? (w_s_in ^ r_in_state) : w_s_in;

    always_comb begin
        w_all_done = 1'b1;
        w_err      = 1'b0;
        w_word     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_all_done = w_all_done & (|w_d[2*i +: 2]);
            w_err      = w_err | dr_illegal(w_d[2*i +: 2]);
            w_word[i]  = dr_decode(w_d[2*i +: 2]);
        end
    end

    // Two equal consecutive samples filter out rail skew across bits.
    assign w_qual   = w_all_done && (w_s_in == r_s_prev);
    assign w_spacer = (w_s_in == '0) && (r_s_prev == '0);
    assign w_pop    = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_go_ack    = 1'b0;
        case (r_state)
            IDLE:    if (w_qual) w_state_nxt = HOLD;
            HOLD:    if (r_dly == '0 && (!w_full || w_pop)) begin
                         w_state_nxt = ACK;
                         w_go_ack    = 1'b1;
                     end
            ACK:     w_state_nxt = (LP_ENC == ENC_FP) ? SPACER : IDLE;
            SPACER:  if (w_spacer) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ack, push and counters are registered on the edge entering ACK, so
    // ack_o changes together with the state and the FIFO sees the push then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_s_prev   <= '0;
            r_in_state <= '0;
            r_word     <= '0;
            r_err      <= 1'b0;
            r_dly      <= '0;
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
            tok_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_s_prev <= w_s_in;
            if (r_state == IDLE && w_qual) begin
                r_word <= w_word;
                r_err  <= w_err;
                r_dly  <= DLY_W'(ACK_DELAY);
            end else if (r_state == HOLD && r_dly != '0) begin
                r_dly <= r_dly - 1'b1;
            end
            if (w_go_ack) begin
                if (LP_ENC == ENC_TP) begin
                    ack_o      <= ~ack_o;
                    r_in_state <= w_s_in;
                end else begin
                    ack_o <= 1'b1;
                end
                if (tok_cnt != '1) tok_cnt <= tok_cnt + 1'b1;
            end
            if (r_state == SPACER && w_spacer) ack_o <= 1'b0;
            if (err_clr) begin
                err_o   <= 1'b0;
                err_cnt <= '0;
            end else if (w_go_ack && r_err) begin
                err_o <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    sync_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_go_ack),
        .i_data  ({r_err, r_word}),
        .i_pop   (w_pop),
        .o_data  ({out_err, out_data}),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = !w_empty;

endmodule

// File: tb/tb_dr_link_rx.sv
// tb/tb_dr_link_rx.sv - scoreboard bench for dr_link_rx in two-phase and four-phase modes
module tb_dr_link_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] tp_in;
    logic        tp_ack, tp_err_w, tp_valid, tp_ready, tp_err_o, tp_clr;
    logic [7:0]  tp_data;
    logic [15:0] tp_tok, tp_errc;
    logic [7:0]  fp_in;
    logic        fp_ack, fp_err_w, fp_valid, fp_ready, fp_err_o, fp_clr;
    logic [3:0]  fp_data;
    logic [15:0] fp_tok, fp_errc;

    int checks = 0;
    int failures = 0;
    int tp_pops = 0;
    int tp_tok_exp = 0;
    int tp_err_exp = 0;
    logic tp_ack_exp = 1'b0;
    logic [8:0] tp_q[$];
    logic [4:0] fp_q[$];
    logic [8:0] tp_head;
    logic [4:0] fp_head;

    dr_link_rx #(.ENC("TP"), .WIDTH(8)) u_tp (
        .clk(clk), .rst_n(rst_n), .in(tp_in), .ack_o(tp_ack),
        .out_data(tp_data), .out_err(tp_err_w), .out_valid(tp_valid), .out_ready(tp_ready),
        .err_o(tp_err_o), .err_clr(tp_clr), .tok_cnt(tp_tok), .err_cnt(tp_errc)
    );

    dr_link_rx #(.ENC("FP"), .WIDTH(4)) u_fp (
        .clk(clk), .rst_n(rst_n), .in(fp_in), .ack_o(fp_ack),
        .out_data(fp_data), .out_err(fp_err_w), .out_valid(fp_valid), .out_ready(fp_ready),
        .err_o(fp_err_o), .err_clr(fp_clr), .tok_cnt(fp_tok), .err_cnt(fp_errc)
    );

    always @(negedge clk) begin
        if (rst_n && tp_valid && tp_ready) begin
            checks++;
            tp_pops++;
            if (tp_q.size() == 0) begin
                failures++;
                $display("FAIL tp_unexpected_word got=%h expected=none", {tp_err_w, tp_data});
            end else begin
                tp_head = tp_q.pop_front();
                if ({tp_err_w, tp_data} !== tp_head) begin
                    failures++;
                    $display("FAIL tp_word got=%h expected=%h", {tp_err_w, tp_data}, tp_head);
                end
            end
        end
        if (rst_n && fp_valid && fp_ready) begin
            checks++;
            if (fp_q.size() == 0) begin
                failures++;
                $display("FAIL fp_unexpected_word got=%h expected=none", {fp_err_w, fp_data});
            end else begin
                fp_head = fp_q.pop_front();
                if ({fp_err_w, fp_data} !== fp_head) begin
                    failures++;
                    $display("FAIL fp_word got=%h expected=%h", {fp_err_w, fp_data}, fp_head);
                end
            end
        end
    end

    task automatic tp_drive(input logic [7:0] v, input logic [7:0] emask);
        for (int i = 0; i < 8; i++) begin
            if (emask[i])  tp_in[2*i +: 2] = tp_in[2*i +: 2] ^ 2'b11;
            else if (v[i]) tp_in[2*i+1] = ~tp_in[2*i+1];
            else           tp_in[2*i]   = ~tp_in[2*i];
        end
        tp_q.push_back({|emask, v | emask});
    endtask

    task automatic wait_tp_ack(output int lat);
        logic prev;
        prev = tp_ack;
        lat  = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (tp_ack !== prev) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tp_in = '0; fp_in = '0;
        tp_ready = 1'b1; fp_ready = 1'b1; tp_clr = 1'b0; fp_clr = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({tp_ack, tp_valid, tp_err_o} !== 3'b000) begin
            failures++; $display("FAIL reset_tp_flags got=%b expected=000", {tp_ack, tp_valid, tp_err_o});
        end
        checks++;
        if ({tp_tok, tp_errc} !== 32'd0) begin
            failures++; $display("FAIL reset_tp_counters got=%h expected=0", {tp_tok, tp_errc});
        end
        checks++;
        if ({fp_ack, fp_valid, fp_err_o} !== 3'b000) begin
            failures++; $display("FAIL reset_fp_flags got=%b expected=000", {fp_ack, fp_valid, fp_err_o});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_tp_basic;
        int lat;
        logic [7:0] vals [2];
        vals[0] = 8'hA5;
        vals[1] = 8'h5A;
        tp_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tp_drive(vals[n], 8'h00);
            wait_tp_ack(lat);
            tp_tok_exp++;
            tp_ack_exp = ~tp_ack_exp;
            checks++;
            if (lat !== 5) begin
                failures++; $display("FAIL tp_ack_latency token=%0d got=%0d expected=5", n, lat);
            end
            checks++;
            if (tp_ack !== tp_ack_exp) begin
                failures++; $display("FAIL tp_ack_level token=%0d got=%b expected=%b", n, tp_ack, tp_ack_exp);
            end
            repeat (3) @(posedge clk); #1;
            checks++;
            if (tp_tok !== 16'(tp_tok_exp)) begin
                failures++; $display("FAIL tp_tok_cnt got=%0d expected=%0d", tp_tok, tp_tok_exp);
            end
        end
    endtask

    task automatic test_fp;
        int lat;
        logic dropped;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) fp_in[2*i +: 2] = (4'h9 >> i) & 4'h1 ? 2'b10 : 2'b01;
            fp_q.push_back({1'b0, 4'h9});
            lat = 0;
            for (int k = 1; k <= 30; k++) begin
                @(posedge clk); #1;
                if (fp_ack === 1'b1) begin lat = k; break; end
            end
            checks++;
            if (lat !== 5) begin
                failures++; $display("FAIL fp_ack_rise round=%0d got=%0d expected=5", n, lat);
            end
            fp_in = 8'h02;
            dropped = 1'b0;
            repeat (8) begin
                @(posedge clk); #1;
                if (fp_ack !== 1'b1) dropped = 1'b1;
            end
            checks++;
            if (dropped !== 1'b0) begin
                failures++; $display("FAIL fp_ack_held_partial_spacer round=%0d got=dropped expected=held", n);
            end
            fp_in = 8'h00;
            lat = 0;
            for (int k = 1; k <= 30; k++) begin
                @(posedge clk); #1;
                if (fp_ack === 1'b0) begin lat = k; break; end
            end
            checks++;
            if (lat == 0) begin
                failures++; $display("FAIL fp_ack_fall round=%0d got=timeout expected=fall", n);
            end
            repeat (3) @(posedge clk); #1;
        end
        checks++;
        if (fp_tok !== 16'd3 || fp_q.size() != 0) begin
            failures++; $display("FAIL fp_tok_cnt got=%0d pending=%0d expected=3/0", fp_tok, fp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int pops0;
        tp_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tp_drive(8'h10 + 8'(n), 8'h00);
            wait_tp_ack(lat);
            tp_tok_exp++;
            tp_ack_exp = ~tp_ack_exp;
            checks++;
            if (lat !== 5) begin
                failures++; $display("FAIL bp_fill_ack token=%0d got=%0d expected=5", n, lat);
            end
        end
        tp_drive(8'hC3, 8'h00);
        repeat (15) @(posedge clk); #1;
        checks++;
        if (tp_ack !== tp_ack_exp || tp_tok !== 16'(tp_tok_exp)) begin
            failures++; $display("FAIL bp_withheld got=ack%b/tok%0d expected=ack%b/tok%0d", tp_ack, tp_tok, tp_ack_exp, tp_tok_exp);
        end
        pops0 = tp_pops;
        tp_ready = 1'b1;
        @(posedge clk); #1;
        tp_ready = 1'b0;
        tp_tok_exp++;
        tp_ack_exp = ~tp_ack_exp;
        checks++;
        if (tp_ack !== tp_ack_exp || tp_valid !== 1'b1) begin
            failures++; $display("FAIL bp_release got=ack%b/valid%b expected=ack%b/valid1", tp_ack, tp_valid, tp_ack_exp);
        end
        tp_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (tp_pops - pops0 != 5 || tp_q.size() != 0 || tp_tok !== 16'(tp_tok_exp)) begin
            failures++; $display("FAIL bp_drain got=%0d pops/%0d pending expected=5/0", tp_pops - pops0, tp_q.size());
        end
    endtask

    task automatic test_skew;
        int lat;
        logic bad;
        tp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tp_in[2*i+1] = ~tp_in[2*i+1];
        tp_q.push_back({1'b0, 8'hFF});
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (tp_ack !== tp_ack_exp || tp_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++; $display("FAIL skew_early got=ack_or_valid expected=none");
        end
        for (int i = 4; i < 8; i++) tp_in[2*i+1] = ~tp_in[2*i+1];
        wait_tp_ack(lat);
        tp_tok_exp++;
        tp_ack_exp = ~tp_ack_exp;
        checks++;
        if (lat !== 5) begin
            failures++; $display("FAIL skew_ack got=%0d expected=5", lat);
        end
        repeat (4) @(posedge clk); #1;
        checks++;
        if (tp_tok !== 16'(tp_tok_exp) || tp_q.size() != 0) begin
            failures++; $display("FAIL skew_single_word got=%0d expected=%0d", tp_tok, tp_tok_exp);
        end
    endtask

    task automatic test_error;
        int lat;
        tp_drive(8'h00, 8'h04);
        wait_tp_ack(lat);
        tp_tok_exp++;
        tp_err_exp++;
        tp_ack_exp = ~tp_ack_exp;
        checks++;
        if (lat !== 5) begin
            failures++; $display("FAIL err_token_acked got=%0d expected=5", lat);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (tp_err_o !== 1'b1 || tp_errc !== 16'(tp_err_exp)) begin
            failures++; $display("FAIL err_flag got=%b/%0d expected=1/%0d", tp_err_o, tp_errc, tp_err_exp);
        end
        tp_clr = 1'b1;
        @(posedge clk); #1;
        tp_clr = 1'b0;
        tp_err_exp = 0;
        checks++;
        if (tp_err_o !== 1'b0 || tp_errc !== 16'(tp_err_exp) || tp_tok !== 16'(tp_tok_exp)) begin
            failures++; $display("FAIL err_clr got=%b/%0d/%0d expected=0/0/%0d", tp_err_o, tp_errc, tp_tok, tp_tok_exp);
        end
    endtask

    task automatic test_reset_midop;
        int lat;
        tp_ready = 1'b0;
        tp_drive(8'h11, 8'h00);
        wait_tp_ack(lat);
        tp_drive(8'h22, 8'h00);
        wait_tp_ack(lat);
        tp_drive(8'h33, 8'h00);
        repeat (4) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tp_ack, tp_valid, tp_err_o} !== 3'b000 || {tp_tok, tp_errc} !== 32'd0) begin
            failures++; $display("FAIL midop_reset got=%b/%0d/%0d expected=000/0/0", {tp_ack, tp_valid, tp_err_o}, tp_tok, tp_errc);
        end
        tp_q.delete();
        tp_in = '0;
        tp_tok_exp = 0;
        tp_ack_exp = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tp_ready = 1'b1;
        @(posedge clk); #1;
        tp_drive(8'h3C, 8'h00);
        wait_tp_ack(lat);
        tp_tok_exp++;
        tp_ack_exp = ~tp_ack_exp;
        checks++;
        if (lat !== 5 || tp_ack !== tp_ack_exp) begin
            failures++; $display("FAIL midop_first_token got=%0d/ack%b expected=5/ack%b", lat, tp_ack, tp_ack_exp);
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (tp_tok !== 16'(tp_tok_exp) || tp_q.size() != 0) begin
            failures++; $display("FAIL midop_tok got=%0d pending=%0d expected=%0d/0", tp_tok, tp_q.size(), tp_tok_exp);
        end
    endtask

    initial begin
        test_reset;
        test_tp_basic;
        test_fp;
        test_backpressure;
        test_skew;
        test_error;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
